// File: rtl/iomem_timer.sv
// iomem_timer: prescaled 32-bit down-counting timer slave on the picosoc iomem bus.
module iomem_timer #(
  parameter logic [7:0] ADDR_BASE = 8'h04,
  parameter int         PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);
  logic ready_q, ready_d, irq_q, irq_d, pend_q, pend_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic [31:0] load_q, load_d, count_q, count_d, rdata_q, rdata_d;
  logic hit, wr, tick, expire, ctrl_wr, presc_wr, load_wr, clr;
  logic [2:0] sel;
  logic [31:0] wmask, rd_val;
  assign wmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  always_comb begin
    sel = iomem_addr[4:2];
    hit = iomem_valid & ~ready_q & (iomem_addr[31:24] == ADDR_BASE);
    wr = hit & (|iomem_wstrb);
    ctrl_wr = wr & (sel == 3'd0) & iomem_wstrb[0];
    presc_wr = wr & (sel == 3'd1);
    load_wr = wr & (sel == 3'd2);
    clr = wr & (sel == 3'd3) & iomem_wstrb[0] & iomem_wdata[0];
    tick = ctrl_q[0] & (pcnt_q == presc_q);
    // a LOAD write swallows a coincident tick, so it can neither expire nor decrement
    expire = tick & ~load_wr & (count_q == 32'd0);
    rd_val = sel == 3'd0 ? {29'd0, ctrl_q} :
             sel == 3'd1 ? 32'(presc_q) :
             sel == 3'd2 ? load_q :
             sel == 3'd3 ? {31'd0, pend_q} :
             sel == 3'd4 ? count_q : 32'd0;
    ready_d = hit;
    rdata_d = hit ? rd_val : rdata_q;
    irq_d = pend_q & ctrl_q[2];
    pend_d = expire | (pend_q & ~clr);
    ctrl_d = ctrl_wr ? iomem_wdata[2:0] : {ctrl_q[2:1], ctrl_q[0] & ~(expire & ~ctrl_q[1])};
    presc_d = presc_wr ? PRESC_W'((iomem_wdata & wmask) | (32'(presc_q) & ~wmask)) : presc_q;
    load_d = load_wr ? (iomem_wdata & wmask) | (load_q & ~wmask) : load_q;
    count_d = load_wr ? load_d :
              ~tick ? count_q :
              count_q != 32'd0 ? count_q - 32'd1 :
              ctrl_q[1] ? load_q : count_q;
    pcnt_d = (~ctrl_q[0] | tick | presc_wr | load_wr) ? '0 : pcnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      irq_q <= 1'b0;
      pend_q <= 1'b0;
      ctrl_q <= '0;
      presc_q <= '0;
      pcnt_q <= '0;
      load_q <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      irq_q <= irq_d;
      pend_q <= pend_d;
      ctrl_q <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q <= pcnt_d;
      load_q <= load_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq = irq_q;
endmodule
